// File: rtl/bt_cmd_ctrl.sv
// Frame sequencer behind the HC06 UART receiver: assembles HEADER/CMD/ARG/CHK
// frames, issues validated commands over valid/ready and tracks link errors.
module bt_cmd_ctrl #(
  parameter logic [7:0] HEADER      = 8'hA5,
  parameter int         TIMEOUT_CYC = 104166,
  parameter int         TW          = 17
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] cmd_code,
  output logic [7:0] cmd_arg,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic       busy,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, GET_CMD, GET_ARG, GET_CHK, ISSUE} state_t;

  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  state_t        state_reg, state_next;
  logic [7:0]    cmd_byte_reg, cmd_byte_next;
  logic [7:0]    arg_byte_reg, arg_byte_next;
  logic [7:0]    code_reg, code_next;
  logic [7:0]    arg_reg, arg_next;
  logic          valid_reg, valid_next;
  logic          busy_reg, busy_next;
  logic          err_reg, err_next;
  logic [7:0]    cnt_reg, cnt_next;
  logic [TW-1:0] tmo_reg, tmo_next;
  logic          err_event;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_reg    <= IDLE;
      cmd_byte_reg <= 8'd0;
      arg_byte_reg <= 8'd0;
      code_reg     <= 8'd0;
      arg_reg      <= 8'd0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      err_reg      <= 1'b0;
      cnt_reg      <= 8'd0;
      tmo_reg      <= '0;
    end else begin
      state_reg    <= state_next;
      cmd_byte_reg <= cmd_byte_next;
      arg_byte_reg <= arg_byte_next;
      code_reg     <= code_next;
      arg_reg      <= arg_next;
      valid_reg    <= valid_next;
      busy_reg     <= busy_next;
      err_reg      <= err_next;
      cnt_reg      <= cnt_next;
      tmo_reg      <= tmo_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    cmd_byte_next = cmd_byte_reg;
    arg_byte_next = arg_byte_reg;
    code_next     = code_reg;
    arg_next      = arg_reg;
    valid_next    = valid_reg;
    tmo_next      = tmo_reg;
    err_event     = 1'b0;

    case (state_reg)
      IDLE: begin
        tmo_next = '0;
        if (rx_valid && rx_data == HEADER) state_next = GET_CMD;
      end
      GET_CMD, GET_ARG, GET_CHK: begin
        // A byte arriving on the expiry cycle still counts as in time.
        if (rx_valid) begin
          tmo_next = '0;
          if (state_reg == GET_CMD) begin
            cmd_byte_next = rx_data;
            state_next    = GET_ARG;
          end else if (state_reg == GET_ARG) begin
            arg_byte_next = rx_data;
            state_next    = GET_CHK;
          end else if (rx_data == (cmd_byte_reg ^ arg_byte_reg)) begin
            code_next  = cmd_byte_reg;
            arg_next   = arg_byte_reg;
            valid_next = 1'b1;
            state_next = ISSUE;
          end else begin
            err_event  = 1'b1;
            state_next = IDLE;
          end
        end else if (tmo_reg == TMO_LAST) begin
          tmo_next   = '0;
          err_event  = 1'b1;
          state_next = IDLE;
        end else begin
          tmo_next = tmo_reg + TW'(1);
        end
      end
      ISSUE: begin
        tmo_next = '0;
        if (cmd_ready) begin
          valid_next = 1'b0;
          state_next = (rx_valid && rx_data == HEADER) ? GET_CMD : IDLE;
        end else if (rx_valid) begin
          err_event = 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        valid_next = 1'b0;
        tmo_next   = '0;
      end
    endcase

    busy_next = (state_next != IDLE);
    err_next  = err_event;
    cnt_next  = (err_event && cnt_reg != 8'hFF) ? cnt_reg + 8'd1 : cnt_reg;
  end

  assign cmd_code  = code_reg;
  assign cmd_arg   = arg_reg;
  assign cmd_valid = valid_reg;
  assign busy      = busy_reg;
  assign frame_err = err_reg;
  assign err_cnt   = cnt_reg;

endmodule
